// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the system-bus controller: FSM state encoding,
// default error word, counter width and small decode helpers.
package bus_ctrl_pkg;

  // Four-state access sequencer, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_IO   = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  // Read data returned when a peripheral never acknowledges.
  localparam logic [31:0] DEFAULT_ERR_WORD = 32'hFFFF_FFFF;

  // Width of the shared wait / timeout down-counter.
  localparam int CNT_WIDTH = 8;

  // A CPU access is pending whenever either strobe is high.
  function automatic logic is_request(input logic re, input logic we);
    return re | we;
  endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// Bundle of CPU data-bus, SRAM and peripheral-port signals seen by bus_ctrl.
// The slave modport is the controller; the master modport is everything
// around it (CPU, SRAM, peripherals).
interface bus_ctrl_if #(
  parameter int SRAM_ADDR_WIDTH = 16
) ();

  // CPU data bus
  logic [31:0]                db_addr;
  logic [31:0]                db_dataOut;
  logic                       db_re;
  logic                       db_we;
  logic                       db_io;
  logic [31:0]                db_dataIn;
  logic                       db_ready;
  logic                       bus_err;

  // Synchronous SRAM
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]                sram_wdata;
  logic [31:0]                sram_rdata;
  logic                       sram_ce;
  logic                       sram_oe;
  logic                       sram_we;

  // Peripheral req/ack port
  logic [31:0]                io_addr;
  logic [31:0]                io_wdata;
  logic [31:0]                io_rdata;
  logic                       io_req;
  logic                       io_we;
  logic                       io_ack;

  modport slave (
    input  db_addr, db_dataOut, db_re, db_we, db_io,
    output db_dataIn, db_ready, bus_err,
    output sram_addr, sram_wdata, sram_ce, sram_oe, sram_we,
    input  sram_rdata,
    output io_addr, io_wdata, io_req, io_we,
    input  io_rdata, io_ack
  );

  modport master (
    output db_addr, db_dataOut, db_re, db_we, db_io,
    input  db_dataIn, db_ready, bus_err,
    input  sram_addr, sram_wdata, sram_ce, sram_oe, sram_we,
    output sram_rdata,
    output io_rdata, io_ack,
    input  io_addr, io_wdata, io_req, io_we
  );

endinterface

// File: rtl/bus_wait_counter.sv
// Loadable 8-bit down-counter shared by the SRAM wait-state sequence and the
// peripheral timeout. It stops at zero and flags it.
module bus_wait_counter
  import bus_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 res,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_r;

  // Load takes priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clk) begin
    if (!res) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - 8'd1;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/bus_ctrl.sv
// System-bus controller: turns CPU data-bus accesses into fixed-latency SRAM
// cycles or timeout-guarded req/ack peripheral cycles, then returns read data
// with a one-cycle ready pulse. All outputs are registered.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int          SRAM_ADDR_WIDTH = 16,
  parameter int          WAIT_STATES     = 1,
  parameter int          IO_TIMEOUT      = 64,
  parameter logic [31:0] ERR_WORD        = DEFAULT_ERR_WORD
) (
  input logic      clk,
  input logic      res,
  bus_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_STATES);
  localparam logic [CNT_WIDTH-1:0] IO_LOAD   = CNT_WIDTH'(IO_TIMEOUT - 1);

  bus_state_e           state_r;
  logic                 write_r;
  logic                 cnt_load_s;
  logic                 cnt_en_s;
  logic                 cnt_zero_s;
  logic [CNT_WIDTH-1:0] cnt_val_s;

  // Counter is armed on leaving IDLE with the length of the coming phase.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_val_s  = WAIT_LOAD;
    if ((state_r == ST_IDLE) && is_request(bus.db_re, bus.db_we)) begin
      cnt_load_s = 1'b1;
      if (bus.db_io) begin
        cnt_val_s = IO_LOAD;
      end else begin
        cnt_val_s = WAIT_LOAD;
      end
    end else begin
      cnt_load_s = 1'b0;
    end
  end

  assign cnt_en_s = (state_r == ST_MEM) || (state_r == ST_IO);

  bus_wait_counter u_wait_counter (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load_s),
    .en       (cnt_en_s),
    .load_val (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Access sequencer with registered outputs. The SRAM/IO address and data
  // registers double as the latch of the CPU request taken in IDLE.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_r        <= ST_IDLE;
      write_r        <= 1'b0;
      bus.db_dataIn  <= 32'h0000_0000;
      bus.db_ready   <= 1'b0;
      bus.bus_err    <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= 32'h0000_0000;
      bus.sram_ce    <= 1'b0;
      bus.sram_oe    <= 1'b0;
      bus.sram_we    <= 1'b0;
      bus.io_addr    <= 32'h0000_0000;
      bus.io_wdata   <= 32'h0000_0000;
      bus.io_req     <= 1'b0;
      bus.io_we      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_request(bus.db_re, bus.db_we)) begin
            // A simultaneous read and write strobe is treated as a write.
            write_r <= bus.db_we;
            if (bus.db_io) begin
              state_r      <= ST_IO;
              bus.io_req   <= 1'b1;
              bus.io_we    <= bus.db_we;
              bus.io_addr  <= bus.db_addr;
              bus.io_wdata <= bus.db_dataOut;
            end else begin
              state_r       <= ST_MEM;
              bus.sram_ce   <= 1'b1;
              bus.sram_addr <= bus.db_addr[SRAM_ADDR_WIDTH+1:2];
              bus.sram_we   <= bus.db_we;
              bus.sram_oe   <= ~bus.db_we;
              if (bus.db_we) begin
                bus.sram_wdata <= bus.db_dataOut;
              end
            end
          end
        end

        ST_MEM: begin
          if (cnt_zero_s) begin
            if (!write_r) begin
              bus.db_dataIn <= bus.sram_rdata;
            end
            bus.sram_ce  <= 1'b0;
            bus.sram_oe  <= 1'b0;
            bus.sram_we  <= 1'b0;
            bus.db_ready <= 1'b1;
            state_r      <= ST_DONE;
          end
        end

        ST_IO: begin
          // An ack on the final timeout cycle still wins over the timeout.
          if (bus.io_ack) begin
            if (!write_r) begin
              bus.db_dataIn <= bus.io_rdata;
            end
            bus.io_req   <= 1'b0;
            bus.db_ready <= 1'b1;
            state_r      <= ST_DONE;
          end else if (cnt_zero_s) begin
            if (!write_r) begin
              bus.db_dataIn <= ERR_WORD;
            end
            bus.bus_err  <= 1'b1;
            bus.io_req   <= 1'b0;
            bus.db_ready <= 1'b1;
            state_r      <= ST_DONE;
          end
        end

        ST_DONE: begin
          bus.db_ready <= 1'b0;
          state_r      <= ST_IDLE;
        end

        default: begin
          bus.db_ready <= 1'b0;
          bus.sram_ce  <= 1'b0;
          bus.sram_oe  <= 1'b0;
          bus.sram_we  <= 1'b0;
          bus.io_req   <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboard bench for bus_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever db_ready is seen.
module tb_bus_ctrl;

  localparam int AW = 16;
  localparam int WS = 1;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  bus_ctrl_if #(.SRAM_ADDR_WIDTH(AW)) bus ();

  bus_ctrl #(
    .SRAM_ADDR_WIDTH (AW),
    .WAIT_STATES     (WS),
    .IO_TIMEOUT      (TO),
    .ERR_WORD        (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_n;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Edge counter: at a negedge, cyc holds the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (res === 1'b1 && bus.db_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: db_ready=1 at edge %0d, no access pending", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("%s_data", e.tag), bus.db_dataIn, e.data);
        check($sformatf("%s_err", e.tag), {31'd0, bus.bus_err}, {31'd0, e.err});
        check($sformatf("%s_edge", e.tag), 32'(cyc), 32'(e.edge_n));
      end
    end
  end

  // SRAM model: writes land in mem, reads present data ahead of the capture edge.
  logic [31:0] mem [0:255];
  int          we_total = 0;
  logic [AW-1:0] sram_addr_seen = '0;
  always @(negedge clk) begin
    if (bus.sram_ce === 1'b1) begin
      sram_addr_seen = bus.sram_addr;
      if (bus.sram_we === 1'b1) begin
        mem[bus.sram_addr[7:0]] = bus.sram_wdata;
        we_total++;
      end
      if (bus.sram_oe === 1'b1) bus.sram_rdata = mem[bus.sram_addr[7:0]];
    end
  end

  // Peripheral model: acks in IO cycle ack_cycle (0 = never), records req length.
  int          ack_cycle  = 0;
  logic [31:0] io_rdata_v = 32'h0;
  int          io_cnt     = 0;
  int          io_len     = 0;
  logic [31:0] seen_addr  = 32'h0;
  logic [31:0] seen_wdata = 32'h0;
  logic        seen_we    = 1'b0;
  always @(negedge clk) begin
    if (bus.io_req === 1'b1) begin
      io_cnt++;
      bus.io_rdata = io_rdata_v;
      bus.io_ack   = (io_cnt == ack_cycle);
      if (io_cnt == ack_cycle) begin
        seen_addr  = bus.io_addr;
        seen_wdata = bus.io_wdata;
        seen_we    = bus.io_we;
      end
    end else begin
      if (io_cnt != 0) io_len = io_cnt;
      io_cnt     = 0;
      bus.io_ack = 1'b0;
    end
  end

  task automatic wait_ready(input string tag, output int edge_n);
    bit found = 1'b0;
    edge_n = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.db_ready === 1'b1) begin
        found  = 1'b1;
        edge_n = cyc;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no db_ready within 60 cycles, expected one", tag);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic io,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.db_re      = re;
    bus.db_we      = we;
    bus.db_io      = io;
    bus.db_addr    = addr;
    bus.db_dataOut = data;
  endtask

  // One complete access: lat = edges from sampling edge to DONE entry.
  task automatic access(input string tag, input logic re, input logic we, input logic io,
                        input logic [31:0] addr, input logic [31:0] data, input int lat,
                        input logic [31:0] exp_d, input logic exp_e);
    int d;
    @(negedge clk);
    drive(re, we, io, addr, data);
    sb_q.push_back('{exp_d, exp_e, cyc + 1 + lat, tag});
    wait_ready(tag, d);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  int we_before;
  int d1, d2;

  initial begin
    res = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset held with a pending read: nothing may start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, bus.db_ready}, 32'd0);
      check("rst_sram_ce", {31'd0, bus.sram_ce}, 32'd0);
      check("rst_io_req", {31'd0, bus.io_req}, 32'd0);
      check("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
      check("rst_dataIn", bus.db_dataIn, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    res = 1'b1;
    @(negedge clk);

    // SRAM write: word address 4, two write-strobe cycles.
    we_before = we_total;
    access("wr10", 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, WS + 1, 32'h0, 1'b0);
    check("wr10_we_cycles", 32'(we_total - we_before), 32'd2);
    check("wr10_sram_addr", 32'(sram_addr_seen), 32'd4);

    // Second write, re and we both high: must be a write.
    we_before = we_total;
    access("wr20", 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0BAD_BEEF, WS + 1, 32'h0, 1'b0);
    check("wr20_we_cycles", 32'(we_total - we_before), 32'd2);

    // Read back with low address bits set (ignored).
    access("rd13", 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0, WS + 1, 32'hCAFE_F00D, 1'b0);

    // IO read, ack in 3rd IO cycle.
    ack_cycle = 3; io_rdata_v = 32'h1234_5678;
    access("io_rd", 1'b1, 1'b0, 1'b1, 32'h8000_0004, 32'h0, 3, 32'h1234_5678, 1'b0);
    check("io_rd_req_len", 32'(io_len), 32'd3);

    // IO write, ack in 1st cycle; read data must not change.
    ack_cycle = 1; io_rdata_v = 32'hDEAD_0001;
    access("io_wr", 1'b0, 1'b1, 1'b1, 32'h8000_0008, 32'h0000_55AA, 1, 32'h1234_5678, 1'b0);
    check("io_wr_we", {31'd0, seen_we}, 32'd1);
    check("io_wr_wdata", seen_wdata, 32'h0000_55AA);
    check("io_wr_addr", seen_addr, 32'h8000_0008);

    // IO read timeout: req held exactly TO cycles, error word, sticky error.
    ack_cycle = 0;
    access("io_to", 1'b1, 1'b0, 1'b1, 32'h8000_000C, 32'h0, TO, 32'hFFFF_FFFF, 1'b1);
    check("io_to_req_len", 32'(io_len), 32'(TO));

    // Ack on the final timeout cycle counts as an ack.
    ack_cycle = TO; io_rdata_v = 32'hA5A5_0F0F;
    access("io_last", 1'b1, 1'b0, 1'b1, 32'h8000_0010, 32'h0, TO, 32'hA5A5_0F0F, 1'b1);

    // Good SRAM access keeps bus_err set.
    access("rd20", 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, WS + 1, 32'h0BAD_BEEF, 1'b1);

    // Back-to-back: read held through DONE, address changed.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0);
    sb_q.push_back('{32'h0BAD_BEEF, 1'b1, cyc + 1 + WS + 1, "b2b_a"});
    wait_ready("b2b_a", d1);
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
    sb_q.push_back('{32'hCAFE_F00D, 1'b1, cyc + 2 + WS + 1, "b2b_b"});
    wait_ready("b2b_b", d2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("b2b_spacing", 32'(d2 - d1), 32'(WS + 3));
    @(negedge clk);

    // Reset in the middle of an IO access.
    ack_cycle = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h8000_0020, 32'h0);
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("rst_io_req_drop", {31'd0, bus.io_req}, 32'd0);
    check("rst_io_ready", {31'd0, bus.db_ready}, 32'd0);
    check("rst_io_err_clr", {31'd0, bus.bus_err}, 32'd0);
    check("rst_io_dataIn", bus.db_dataIn, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    res = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_io_no_ready", {31'd0, bus.db_ready}, 32'd0);
    end

    // Controller must be back in IDLE with normal latency.
    access("rd_after_rst", 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, WS + 1, 32'hCAFE_F00D, 1'b0);

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Downstream system-bus controller: consumes the CPU's external data bus (the address, data, read/write strobes and IO flag produced by the cache) and returns read data plus a one-cycle ready pulse. Non-IO accesses go to a synchronous SRAM with fixed, parameterised wait states. IO accesses go to a req/ack peripheral port guarded by a timeout. It sits between the CPU top level and the board memory and peripherals.

## Interface
Parameters:
- `SRAM_ADDR_WIDTH`, 16: word-address width of the SRAM.
- `WAIT_STATES`, 1: extra SRAM cycles beyond the first; legal range 0..15.
- `IO_TIMEOUT`, 64: maximum cycles `io_req` is held without `io_ack`; legal range 2..255.
- `ERR_WORD`, 32'hFFFF_FFFF: read data returned on an IO timeout.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `res` in 1: **synchronous, active-low reset**.
- `db_addr` in 32: byte address from the CPU.
- `db_dataOut` in 32: write data from the CPU.
- `db_re`, `db_we`, `db_io` in 1 each: read strobe, write strobe, IO select.
- `db_dataIn` out 32: read data to the CPU.
- `db_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: sticky IO-timeout flag.
- `sram_addr` out `SRAM_ADDR_WIDTH`; `sram_wdata` out 32; `sram_rdata` in 32.
- `sram_ce`, `sram_oe`, `sram_we` out 1 each: SRAM chip enable, output enable, write enable.
- `io_addr` out 32; `io_wdata` out 32; `io_rdata` in 32.
- `io_req` out 1; `io_we` out 1; `io_ack` in 1.

## Operation
- The FSM has four states: IDLE, MEM, IO, DONE.
- **IDLE:**
  - A request is `db_re|db_we`.
  - When a request is present, latch `db_addr`, `db_dataOut`, write = `db_we`, and the target = `db_io`.
  - Go to IO if `db_io`, otherwise MEM.
  - If `db_re` and `db_we` are both high, the access is a write.
- **MEM:**
  - `sram_ce`=1 throughout.
  - `sram_addr` = latched addr[`SRAM_ADDR_WIDTH`+1:2]; the low two bits are ignored.
  - On a write: `sram_we`=1, `sram_wdata` = latched data.
  - On a read: `sram_oe`=1.
  - The state lasts exactly `WAIT_STATES`+1 cycles, counted by the wait counter.
  - On the last cycle, capture `sram_rdata` into `db_dataIn` if reading, then go to DONE.
- **IO:**
  - `io_req`=1; `io_addr`, `io_wdata` and `io_we` come from the latched values.
  - When `io_ack`=1 is sampled: capture `io_rdata` (reads only), go to DONE.
  - If no ack arrives by the `IO_TIMEOUT`-th cycle in IO: go to DONE, `db_dataIn`=`ERR_WORD` on reads, set `bus_err`.
  - An ack on the final cycle counts as an ack, not a timeout.
- **DONE:** `db_ready`=1 for this single cycle, then go to IDLE.
- `db_dataIn` holds its last value until the next completed read. Writes leave it unchanged.
- `bus_err` is cleared only by reset.

## Timing
- All outputs are registered. Reset values:
  - `db_ready`=0, `db_dataIn`=0, `bus_err`=0.
  - All `sram_*` and `io_*` outputs = 0.
  - State = IDLE.
- **SRAM latency:** a request sampled in IDLE at edge n gives `db_ready` high in cycle n+`WAIT_STATES`+2.
- **IO latency:** if `io_ack` is first high in the k-th IO cycle, `db_ready` is high in cycle n+k+1.
- **CPU handshake:**
  - The CPU holds `db_addr`, `db_dataOut`, `db_re`, `db_we` and `db_io` stable until it sees `db_ready`.
  - Inputs are sampled only in IDLE; changes during MEM, IO or DONE are ignored.
  - A request still asserted in the cycle after DONE is treated as a new access (back-to-back). Minimum access spacing is therefore `WAIT_STATES`+3 cycles for SRAM.
- `io_req` drops in the same cycle the FSM enters DONE. The peripheral must drop `io_ack` within one cycle of `io_req` falling.
- **Reset mid-access:** on the next edge, return to IDLE with all strobes low. No `db_ready` pulse is issued and the aborted access is lost.

## Structure
- Shared constants go in a `BusCtrl.vh` header next to `DataBus.vh`: the FSM state encodings (2 bits) and the default `ERR_WORD`.
- Sub-module `bus_wait_counter`:
  - 8-bit loadable down-counter with `load`, `en` and `zero` outputs.
  - Reused for both the SRAM wait-state count and the IO timeout.
  - Loaded with `WAIT_STATES` or `IO_TIMEOUT`-1 on leaving IDLE.

## Test plan
- **Reset:** hold `res`=0 for 3 cycles with `db_re`=1 → `db_ready`, `sram_ce`, `io_req` and `bus_err` all stay 0.
- **SRAM write/read** (`WAIT_STATES`=1):
  - Write `db_addr`=32'h0000_0010, data 32'hCAFE_F00D → `sram_addr`=4, `sram_we` high for 2 cycles, `db_ready` in cycle n+3.
  - Read back the same address → `db_dataIn`=32'hCAFE_F00D with `db_ready`.
- **IO read, ack on 3rd cycle:** `io_rdata`=32'h1234_5678 → `db_dataIn`=32'h1234_5678, `db_ready` in cycle n+4, `bus_err`=0.
- **IO timeout** (`IO_TIMEOUT`=8, never ack):
  - `io_req` high exactly 8 cycles, then `db_ready` with `db_dataIn`=32'hFFFF_FFFF and `bus_err`=1.
  - `bus_err` stays set through a later good access.
- **Back-to-back:** keep `db_re` high across DONE with a new address → the second access completes, giving two `db_ready` pulses spaced `WAIT_STATES`+3 cycles apart.
- **Reset mid-IO:** `res`=0 during IO → `io_req` is 0 on the next edge, no `db_ready`, state returns to IDLE.
